// File: rtl/phase_calc.sv
// phase_calc: iterative CORDIC atan2(y, x) in vectoring mode.
// Result is a signed angle in degrees with 10 fractional bits.
// Two micro-rotations run per clock, so a conversion takes 9 cycles
// from the start edge to the angle update.
// Build option: define PHASECALC_ROUND_EN to round the angle half-up
// (with a clamp at +180 degrees); otherwise the angle is truncated.
module phase_calc (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    input  logic signed [12:0] x,
    input  logic signed [12:0] y,
    output logic signed [18:0] angle
);

    // 180 degrees in the accumulator format (14 fractional bits)
    localparam logic signed [23:0] Z_180     = 24'sd2949120;
    // 180 degrees in the output format (10 fractional bits)
    localparam logic signed [18:0] ANGLE_180 = 19'sd184320;
`ifdef PHASECALC_ROUND_EN
    // Accumulator values at or above this would round past +180 degrees
    localparam logic signed [23:0] Z_CLAMP   = 24'sd2949112;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic signed [15:0] x_q, x_d;
    logic signed [15:0] y_q, y_d;
    logic signed [23:0] z_q, z_d;
    logic               zero_q, zero_d;
    logic               negaxis_q, negaxis_d;
    logic signed [18:0] angle_q, angle_d;

    logic signed [15:0] x_ext, y_ext;
    logic signed [15:0] x_rot, y_rot;
    logic signed [23:0] z_rot;
    logic signed [15:0] x_sh, y_sh;
    logic [3:0]         rot_sh;
    logic signed [18:0] angle_res;

    // atan(2^-i) in degrees scaled by 2^14, rounded to nearest
    function automatic logic signed [23:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 24'sd737280;
            4'd1:    atan_lut = 24'sd435242;
            4'd2:    atan_lut = 24'sd229970;
            4'd3:    atan_lut = 24'sd116736;
            4'd4:    atan_lut = 24'sd58595;
            4'd5:    atan_lut = 24'sd29326;
            4'd6:    atan_lut = 24'sd14667;
            4'd7:    atan_lut = 24'sd7334;
            4'd8:    atan_lut = 24'sd3667;
            4'd9:    atan_lut = 24'sd1833;
            4'd10:   atan_lut = 24'sd917;
            4'd11:   atan_lut = 24'sd458;
            4'd12:   atan_lut = 24'sd229;
            4'd13:   atan_lut = 24'sd115;
            4'd14:   atan_lut = 24'sd57;
            default: atan_lut = 24'sd29;
        endcase
    endfunction

    assign x_ext = {{3{x[12]}}, x};
    assign y_ext = {{3{y[12]}}, y};

    // Two chained micro-rotations: iterations 2*cnt and 2*cnt+1
    always_comb begin
        x_rot  = x_q;
        y_rot  = y_q;
        z_rot  = z_q;
        rot_sh = 4'd0;
        x_sh   = 16'sd0;
        y_sh   = 16'sd0;
        for (int k = 0; k < 2; k++) begin
            rot_sh = {cnt_q, k[0]};
            x_sh   = x_rot >>> rot_sh;
            y_sh   = y_rot >>> rot_sh;
            if (y_rot[15]) begin
                // Y negative: rotate counter-clockwise, angle decreases
                x_rot = x_rot - y_sh;
                y_rot = y_rot + x_sh;
                z_rot = z_rot - atan_lut(rot_sh);
            end else begin
                // Y non-negative: rotate clockwise, angle increases
                x_rot = x_rot + y_sh;
                y_rot = y_rot - x_sh;
                z_rot = z_rot + atan_lut(rot_sh);
            end
        end
    end

    // Reduce the accumulator to the output format
    always_comb begin
`ifdef PHASECALC_ROUND_EN
        if (z_q >= Z_CLAMP) begin
            angle_res = ANGLE_180;
        end else begin
            angle_res = 19'((z_q + 24'sd8) >>> 4);
        end
`else
        angle_res = 19'(z_q >>> 4);
`endif
    end

    // Sequencing: capture/pre-rotate, 8 rotation cycles, final write
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        zero_d    = zero_q;
        negaxis_d = negaxis_q;
        angle_d   = angle_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = 3'd0;
                    zero_d    = (x == 13'sd0) && (y == 13'sd0);
                    negaxis_d = x[12] && (y == 13'sd0);
                    if (x[12]) begin
                        // Left half-plane: rotate by 180 so X starts positive
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = y[12] ? -Z_180 : Z_180;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = 24'sd0;
                    end
                    state_d = S_ROT;
                end
            end
            S_ROT: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Degenerate inputs get their exact answers here
                if (zero_q) begin
                    angle_d = 19'sd0;
                end else if (negaxis_q) begin
                    angle_d = ANGLE_180;
                end else begin
                    angle_d = angle_res;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            x_q       <= 16'sd0;
            y_q       <= 16'sd0;
            z_q       <= 24'sd0;
            zero_q    <= 1'b0;
            negaxis_q <= 1'b0;
            angle_q   <= 19'sd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            zero_q    <= zero_d;
            negaxis_q <= negaxis_d;
            angle_q   <= angle_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign angle = angle_q;

endmodule

// File: tb/tb_phase_calc.sv
// tb_phase_calc: directed bench for the CORDIC phase calculator.
// Expected angles come from a bit-level model of the vectoring
// algorithm whose arctangent table is computed with $atan.
module tb_phase_calc;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               busy;
    logic signed [12:0] x;
    logic signed [12:0] y;
    logic signed [18:0] angle;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int atan_tab[16];

    always #5 clock = ~clock;

    phase_calc dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .x     (x),
        .y     (y),
        .angle (angle)
    );

    // Reference model of one conversion
    function automatic int model(input int xi, input int yi);
        logic signed [15:0] xx, yy, xs, ys;
        logic signed [23:0] zz, zr;
        if (xi == 0 && yi == 0) return 0;
        if (xi < 0 && yi == 0) return 184320;
        xx = 16'(xi);
        yy = 16'(yi);
        zz = 24'sd0;
        if (xi < 0) begin
            xx = -xx;
            yy = -yy;
            zz = (yi < 0) ? -24'sd2949120 : 24'sd2949120;
        end
        for (int i = 0; i < 16; i++) begin
            xs = xx >>> i;
            ys = yy >>> i;
            if (yy[15]) begin
                xx = xx - ys;
                yy = yy + xs;
                zz = zz - 24'(atan_tab[i]);
            end else begin
                xx = xx + ys;
                yy = yy - xs;
                zz = zz + 24'(atan_tab[i]);
            end
        end
`ifdef PHASECALC_ROUND_EN
        if (zz >= 24'sd2949112) return 184320;
        zr = (zz + 24'sd8) >>> 4;
`else
        zr = zz >>> 4;
`endif
        return int'(19'(zr));
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
            $error("check %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one start pulse; returns just after the capture edge
    task automatic launch(input int xi, input int yi);
        @(negedge clock);
        x     = 13'(xi);
        y     = 13'(yi);
        start = 1'b1;
        exp_q.push_back(model(xi, yi));
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges until busy drops, then score the angle
    task automatic wait_done(input string tag, input int xi, input int yi);
        int n;
        int e;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, 9);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, angle, e);
        end
        $display("conv %s x=%0d y=%0d angle=%0d", tag, xi, yi, angle);
    endtask

    task automatic convert(input string tag, input int xi, input int yi);
        logic signed [18:0] prev;
        prev = angle;
        launch(xi, yi);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_hold"}, angle, prev);
        wait_done(tag, xi, yi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        real p;
        p = 1.0;
        for (int i = 0; i < 16; i++) begin
            atan_tab[i] = int'($atan(p) * 180.0 / 3.14159265358979 * 16384.0);
            p = p / 2.0;
        end

        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_angle", angle, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("idle_busy", busy, 0);
        check("idle_angle", angle, 0);

        // Quadrants, axes and extremes
        convert("q1", 123, 456);
        convert("q2", -123, 456);
        convert("pos_y", 0, 456);
        convert("neg_x", -123, 0);
        check("neg_x_exact", angle, 184320);
        convert("neg_y", 0, -456);
        convert("pos_x", 123, 0);
        convert("origin", 0, 0);
        check("origin_exact", angle, 0);
        convert("q3", -123, -456);
        convert("q4", 123, -456);
        convert("extreme", -4096, -4096);
        convert("max_q1", 4095, 4095);

        // Starts while busy are ignored; inputs changed mid-run are ignored
        launch(200, -300);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            start = (k == 3 || k == 8);
            if (k == 2) begin
                x = -13'sd4000;
                y = 13'sd17;
            end
            @(posedge clock);
            #1;
            check($sformatf("hs_busy_%0d", k), busy, (k < 9) ? 1 : 0);
        end
        @(negedge clock);
        start = 1'b0;
        if (exp_q.size() != 0) check("hs_angle", angle, exp_q.pop_front());
        $display("conv hs x=200 y=-300 angle=%0d", angle);
        @(posedge clock);
        #1;
        check("hs_no_queue", busy, 0);

        // Start held high: one conversion every 10 cycles
        @(negedge clock);
        x     = 13'sd300;
        y     = -13'sd50;
        start = 1'b1;
        exp_q.push_back(model(300, -50));
        @(posedge clock);
        #1;
        check("held_a_busy", busy, 1);
        @(negedge clock);
        x = -13'sd77;
        y = -13'sd900;
        exp_q.push_back(model(-77, -900));
        wait_done("held_a", 300, -50);
        @(posedge clock);
        #1;
        check("held_b_busy", busy, 1);
        @(negedge clock);
        start = 1'b0;
        wait_done("held_b", -77, -900);

        // Reset mid-conversion, then a start coincident with reset
        convert("pre_rst", 1000, 700);
        launch(-500, 800);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_busy", busy, 0);
        check("abort_angle", angle, 0);
        exp_q.delete();
        @(negedge clock);
        start = 1'b1;
        x     = 13'sd1;
        y     = 13'sd1;
        @(posedge clock);
        #1;
        check("rst_start_ign", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_angle", angle, 0);
        convert("one_one", 1, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
